nosp_flow_ctrl: RTL

- Sequences the non-downsampled demod datapath: input FIFO → COSTAS_LOOP → output FIFO → DAC.
- Replaces the ad-hoc combinational enable with a state machine that:
  - holds the Costas loop in reset until the input FIFO is out of reset-busy;
  - prefills the input FIFO before reading starts;
  - aligns output-FIFO writes with the loop's pipeline latency;
  - paces output-FIFO reads for the DAC.
- Reports underrun and back-pressure statistics for ILA/debug.

---
 rtl/nosp_ctrl_pkg.sv | 25 ++
 rtl/nosp_flow_ctrl_if.sv | 40 ++++
 rtl/nosp_flow_ctrl_valid_dly.sv | 34 +++
 rtl/nosp_flow_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/nosp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// nosp_ctrl_pkg : shared types and constants for the non-downsampled flow ctrl
// Revision      : 1.0
// ============================================================================
package nosp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_RST = 2'b00,
        ST_PREFILL  = 2'b01,
        ST_RUN      = 2'b10,
        ST_FLUSH    = 2'b11
    } state_e;

    localparam int              STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    // Saturating increment used by the debug statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic              en);
        return (en && (v != STAT_MAX)) ? v + 1'b1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nosp_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// nosp_flow_ctrl_if : FIFO flags, enables and debug status of the flow ctrl
// Revision          : 1.0
// ============================================================================
interface nosp_flow_ctrl_if #(
    parameter int CNT_W = 10
);
    import nosp_ctrl_pkg::*;

    logic                run;
    logic                infifo_rst_busy;
    logic                infifo_almst_empty;
    logic [CNT_W-1:0]    infifo_rd_count;
    logic                outfifo_almst_full;
    logic                outfifo_empty;
    logic                dsp_rd_en;
    logic                out_wr_en;
    logic                loop_rst;
    logic                outrd_en;
    logic [1:0]          state;
    logic [STAT_W-1:0]   underrun_cnt;
    logic [STAT_W-1:0]   stall_cnt;

    modport master (
        output run, infifo_rst_busy, infifo_almst_empty, infifo_rd_count,
               outfifo_almst_full, outfifo_empty,
        input  dsp_rd_en, out_wr_en, loop_rst, outrd_en, state,
               underrun_cnt, stall_cnt
    );

    modport slave (
        input  run, infifo_rst_busy, infifo_almst_empty, infifo_rd_count,
               outfifo_almst_full, outfifo_empty,
        output dsp_rd_en, out_wr_en, loop_rst, outrd_en, state,
               underrun_cnt, stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/nosp_flow_ctrl_valid_dly.sv
`default_nettype none
// ============================================================================
// valid_dly : PIPE_LAT-deep 1-bit shift register with synchronous clear
// Revision  : 1.0
// ============================================================================
module valid_dly #(
    parameter int PIPE_LAT = 4
) (
    input  wire logic clk,
    input  wire logic clr_i,
    input  wire logic d_i,
    output logic      q_o
);

    logic [PIPE_LAT-1:0] sr_q;

    generate
        if (PIPE_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (clr_i) sr_q <= '0;
                else       sr_q <= d_i;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (clr_i) sr_q <= '0;
                else       sr_q <= {sr_q[PIPE_LAT-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = sr_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: rtl/nosp_flow_ctrl.sv
`default_nettype none
// ============================================================================
// nosp_flow_ctrl : sequences in-FIFO -> Costas loop -> out-FIFO -> DAC
// Revision       : 1.0
// ============================================================================
module nosp_flow_ctrl
    import nosp_ctrl_pkg::*;
#(
    parameter int CNT_W        = 10,
    parameter int PREFILL      = 256,
    parameter int PIPE_LAT     = 4,
    parameter int OUT_DIV      = 1,
    parameter int LOOP_RST_CYC = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    nosp_flow_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_prefill_lvl = CNT_W'(PREFILL);
    localparam logic [7:0]       c_hold_max    = 8'(LOOP_RST_CYC);
    localparam logic [7:0]       c_div_last    = 8'(OUT_DIV - 1);
    localparam logic [3:0]       c_flush_last  = 4'(PIPE_LAT - 1);

    state_e            state_q;
    logic [7:0]        hold_cnt_q;
    logic [3:0]        flush_cnt_q;
    logic [7:0]        div_cnt_q;
    logic              dsp_rd_en_q;
    logic              loop_rst_q;
    logic              out_started_q;
    logic              outrd_en_q;
    logic [STAT_W-1:0] underrun_q;
    logic [STAT_W-1:0] stall_q;
    logic              out_wr_en_w;
    logic              tick_w;
    logic              flush_done_w;
    logic              stop_w;

    assign tick_w       = (div_cnt_q == c_div_last);
    assign flush_done_w = (state_q == ST_FLUSH) && (flush_cnt_q == c_flush_last);
    assign stop_w       = !bus.run || bus.infifo_rst_busy;

    // Outputs are registered from the next state, so loop_rst tracks state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_RST;
            hold_cnt_q  <= '0;
            flush_cnt_q <= '0;
            dsp_rd_en_q <= 1'b0;
            loop_rst_q  <= 1'b1;
        end else begin
            dsp_rd_en_q <= 1'b0;
            case (state_q)
                ST_WAIT_RST: begin
                    loop_rst_q <= 1'b1;
                    if (hold_cnt_q != c_hold_max) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end else if (!stop_w) begin
                        state_q    <= ST_PREFILL;
                        loop_rst_q <= 1'b0;
                    end
                end
                ST_PREFILL: begin
                    if (stop_w) begin
                        state_q    <= ST_WAIT_RST;
                        loop_rst_q <= 1'b1;
                        hold_cnt_q <= '0;
                    end else if (bus.infifo_rd_count >= c_prefill_lvl) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_w) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end else begin
                        dsp_rd_en_q <= !bus.infifo_almst_empty && !bus.outfifo_almst_full;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == c_flush_last) begin
                        state_q    <= ST_WAIT_RST;
                        loop_rst_q <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_WAIT_RST;
            endcase
        end
    end

    valid_dly #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_dly (
        .clk   (clk),
        .clr_i (rst),
        .d_i   (dsp_rd_en_q),
        .q_o   (out_wr_en_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            out_started_q <= 1'b0;
            outrd_en_q    <= 1'b0;
            underrun_q    <= '0;
            stall_q       <= '0;
        end else begin
            div_cnt_q <= tick_w ? 8'd0 : div_cnt_q + 8'd1;
            // Flush exit wins over the final in-flight write landing.
            if (flush_done_w)     out_started_q <= 1'b0;
            else if (out_wr_en_w) out_started_q <= 1'b1;
            outrd_en_q <= tick_w && out_started_q && !bus.outfifo_empty;
            underrun_q <= sat_inc(underrun_q, tick_w && out_started_q && bus.outfifo_empty);
            stall_q    <= sat_inc(stall_q, (state_q == ST_RUN) && bus.outfifo_almst_full);
        end
    end

    assign bus.dsp_rd_en    = dsp_rd_en_q;
    assign bus.out_wr_en    = out_wr_en_w;
    assign bus.loop_rst     = loop_rst_q;
    assign bus.outrd_en     = outrd_en_q;
    assign bus.state        = state_q;
    assign bus.underrun_cnt = underrun_q;
    assign bus.stall_cnt    = stall_q;

endmodule
`default_nettype wire
